bcd_display_scanner: RTL

//  Time-multiplexes a DIGITS-wide packed BCD value onto one shared 7-seg decoder.

---
 rtl/bcd_display_scanner.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner
// Time-multiplexes a packed BCD value, one nibble per digit slot, onto a shared
// 7-segment decoder. Each slot begins with a blank gap to prevent ghosting.
// A new value arrives through a one-deep valid/ready buffer. It moves into the
// display register only at a frame boundary, so a frame never shows a mix of
// two values.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 always shows).
// All outputs are registered. They are loaded from the next-state decode, so
// they line up cycle-for-cycle with the state they describe.
module bcd_display_scanner #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 1000,
  parameter int BLANK  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic [3:0]            bcd_out,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_start
);

  localparam int CW = $clog2(DWELL);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  // Registered state
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   disp;
  logic [4*DIGITS-1:0]   pend;
  logic                  pend_full;

  // Next-state values
  logic [CW-1:0]         cnt_nxt;
  logic [IW-1:0]         idx_nxt;
  logic [4*DIGITS-1:0]   disp_nxt;
  logic [4*DIGITS-1:0]   pend_nxt;
  logic                  pend_full_nxt;
  logic                  slot_end;
  logic                  frame_end;

  // Next-cycle output values
  logic                  blank_lz;
  logic                  show_nxt;
  logic [3:0]            bcd_nxt;
  logic [DIGITS-1:0]     dig_en_nxt;
  logic                  frame_nxt;
  logic                  ready_nxt;

  // Select nibble 'sel' of a packed BCD word
  function automatic logic [3:0] nibble_at(input logic [4*DIGITS-1:0] val,
                                           input logic [IW-1:0] sel);
    logic [3:0] nib;
    nib = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (sel == IW'(k)) begin
        nib = val[4*k +: 4];
      end else begin
        nib = nib;
      end
    end
    return nib;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // True when digit 'sel' (sel > 0) and every more significant digit are zero
  function automatic logic lead_zero(input logic [4*DIGITS-1:0] val,
                                     input logic [IW-1:0] sel);
    logic run;
    logic hit;
    run = 1'b1;
    hit = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run = run & (val[4*k +: 4] == 4'h0);
      if (sel == IW'(k)) begin
        hit = run;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction
`endif

  // Slot/digit sequencing plus handshake capture and frame-boundary transfer
  always_comb begin
    cnt_nxt       = cnt;
    idx_nxt       = idx;
    disp_nxt      = disp;
    pend_nxt      = pend;
    pend_full_nxt = pend_full;
    slot_end      = (cnt == CNT_LAST);
    frame_end     = slot_end && (idx == IDX_LAST);

    if (slot_end) begin
      cnt_nxt = '0;
      if (idx == IDX_LAST) begin
        idx_nxt = '0;
      end else begin
        idx_nxt = idx + IW'(1);
      end
    end else begin
      cnt_nxt = cnt + CW'(1);
    end

    // Transfer and capture are exclusive: capture needs pend_full low
    if (frame_end && pend_full) begin
      disp_nxt      = pend;
      pend_full_nxt = 1'b0;
    end else if (in_valid && !pend_full) begin
      pend_nxt      = in_bcd;
      pend_full_nxt = 1'b1;
    end else begin
      pend_full_nxt = pend_full;
    end
  end

  // Decode the next cycle's outputs from the next state
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    blank_lz = lead_zero(disp_nxt, idx_nxt);
`else
    blank_lz = 1'b0;
`endif
    show_nxt = (cnt_nxt >= CNT_BLANK) && !blank_lz;
    if (show_nxt) begin
      bcd_nxt = nibble_at(disp_nxt, idx_nxt);
    end else begin
      bcd_nxt = 4'hF;
    end
    dig_en_nxt = '0;
    for (int k = 0; k < DIGITS; k++) begin
      dig_en_nxt[k] = show_nxt && (idx_nxt == IW'(k));
    end
    frame_nxt = (cnt_nxt == '0) && (idx_nxt == '0);
    ready_nxt = !pend_full_nxt;
  end

  // State and output registers; reset discards any pending value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      disp        <= '0;
      pend        <= '0;
      pend_full   <= 1'b0;
      in_ready    <= 1'b1;
      bcd_out     <= 4'hF;
      dig_en      <= '0;
      frame_start <= 1'b1;
    end else begin
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      disp        <= disp_nxt;
      pend        <= pend_nxt;
      pend_full   <= pend_full_nxt;
      in_ready    <= ready_nxt;
      bcd_out     <= bcd_nxt;
      dig_en      <= dig_en_nxt;
      frame_start <= frame_nxt;
    end
  end

endmodule
